// File: rtl/led_fader.sv
// Eight-channel LED fader: synchronized on/off targets ramp 8-bit brightness
// up/down once per fade step and drive registered PWM. Define LED_FADER_GAMMA_EN for square-law duty.
module led_fader #(
   parameter int unsigned STEP_PERIODS = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] led_in,
   output logic [7:0] led_out,
   output logic       settled
);

   localparam logic [15:0] STEP_LAST = 16'(STEP_PERIODS - 1);

   logic [7:0]  sync1;
   logic [7:0]  tgt;
   logic [7:0]  pwm_cnt;
   logic [15:0] step_cnt;
   logic [7:0]  b    [8];
   logic [7:0]  duty [8];
   logic        period_end;
   logic        strobe;
   logic [7:0]  led_next;
   logic        settled_next;

   // led_in is asynchronous to clk; only the second stage is ever consumed.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1 <= '0;
         tgt   <= '0;
      end else begin
         sync1 <= led_in;
         tgt   <= sync1;
      end
   end

   assign period_end = (pwm_cnt == 8'hFF);
   assign strobe     = period_end && (step_cnt == STEP_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         pwm_cnt  <= '0;
         step_cnt <= '0;
      end else begin
         pwm_cnt <= pwm_cnt + 8'd1;
         if (period_end) begin
            step_cnt <= (step_cnt == STEP_LAST) ? 16'd0 : step_cnt + 16'd1;
         end
      end
   end

   // Direction follows the current target, so a mid-fade toggle simply
   // reverses from wherever the brightness happens to be.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 8; i++) begin
            b[i] <= '0;
         end
      end else if (strobe) begin
         for (int i = 0; i < 8; i++) begin
            if (tgt[i] && (b[i] != 8'hFF)) begin
               b[i] <= b[i] + 8'd1;
            end else if (!tgt[i] && (b[i] != 8'h00)) begin
               b[i] <= b[i] - 8'd1;
            end
         end
      end
   end

`ifdef LED_FADER_GAMMA_EN
   logic [15:0] sq [8];

   always_comb begin
      for (int i = 0; i < 8; i++) begin
         sq[i]   = 16'(b[i]) * 16'(b[i]);
         duty[i] = (b[i] == 8'hFF) ? 8'hFF : sq[i][15:8];
      end
   end
`else
   always_comb begin
      for (int i = 0; i < 8; i++) begin
         duty[i] = b[i];
      end
   end
`endif

   // Full duty is forced high so that brightness 255 means a solid LED.
   always_comb begin
      led_next     = '0;
      settled_next = 1'b1;
      for (int i = 0; i < 8; i++) begin
         led_next[i] = (duty[i] == 8'hFF) || (pwm_cnt < duty[i]);
         if (tgt[i] ? (b[i] != 8'hFF) : (b[i] != 8'h00)) begin
            settled_next = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         led_out <= '0;
         settled <= 1'b1;
      end else begin
         led_out <= led_next;
         settled <= settled_next;
      end
   end

endmodule

// File: tb/tb_led_fader.sv
// Scoreboard bench for led_fader: per-channel high-cycle counts over aligned
// 256-cycle PWM windows are compared with counts derived from the expected brightness.
module tb_led_fader;

   localparam int SP = 1;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] led_in = 8'hA5;
   logic [7:0] led_out;
   logic       settled;

   led_fader #(.STEP_PERIODS(SP)) dut (
      .clk     (clk),
      .rst     (rst),
      .led_in  (led_in),
      .led_out (led_out),
      .settled (settled)
   );

   always #5 clk = ~clk;

   typedef struct {
      int    win;
      int    ch;
      int    exp;
      string tag;
   } exp_t;

   exp_t sbq[$];
   int   compared   = 0;
   int   mismatched = 0;
   int   cyc        = 0;

   // Number of high cycles per 256-cycle period for a given brightness.
   function automatic int expHigh(input int bv);
      int d;
`ifdef LED_FADER_GAMMA_EN
      d = (bv == 255) ? 255 : ((bv * bv) >> 8);
`else
      d = bv;
`endif
      return (d == 255) ? 256 : d;
   endfunction

   task automatic checkOutput(input string tag, input int actual, input int expected);
      compared++;
      if (actual != expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic rstVal, input logic [7:0] ledVal);
      rst    = rstVal;
      led_in = ledVal;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic expectWindow(input int win, input int ch, input int bv, input string tag);
      exp_t e;
      e.win = win;
      e.ch  = ch;
      e.exp = expHigh(bv);
      e.tag = tag;
      sbq.push_back(e);
   endtask

   // Window k holds brightness b_k (set by strobe k); led_out lags pwm_cnt by one cycle.
   task automatic measureWindow(input int k);
      int   cnt [8];
      int   start;
      exp_t e;
      for (int c = 0; c < 8; c++) cnt[c] = 0;
      start = 256 * k * SP + 1;
      while (cyc < start) tick();
      for (int s = 0; s < 256; s++) begin
         for (int c = 0; c < 8; c++) begin
            if (led_out[c] === 1'b1) cnt[c]++;
         end
         if (s < 255) tick();
      end
      while ((sbq.size() > 0) && (sbq[0].win == k)) begin
         e = sbq.pop_front();
         checkOutput($sformatf("%s_w%0d_ch%0d", e.tag, k, e.ch), cnt[e.ch], e.exp);
      end
   endtask

   task automatic releaseReset();
      rst = 1'b0;
      cyc = 0;
   endtask

   initial begin
      int fell;

      applyStimulus(1'b1, 8'hA5);
      for (int i = 0; i < 3; i++) begin
         tick();
         checkOutput($sformatf("rst_led_out_%0d", i), int'(led_out), 0);
         checkOutput($sformatf("rst_settled_%0d", i), int'(settled), 1);
      end

      releaseReset();
      fell = -1;
      for (int i = 0; i <= 4; i++) begin
         if ((settled === 1'b0) && (fell < 0)) fell = cyc;
         if (i < 4) tick();
      end
      checkOutput("settled_fall_cycle", fell, 3);

      expectWindow(1, 0, 1, "a_up");
      expectWindow(1, 1, 0, "a_down");
      expectWindow(16, 0, 16, "a_up");
      expectWindow(49, 0, 49, "a_up");
      expectWindow(49, 2, 49, "a_up");
      expectWindow(49, 3, 0, "a_down");
      measureWindow(1);
      measureWindow(16);
      measureWindow(49);

      for (int i = 0; i < 100; i++) tick();
      applyStimulus(1'b1, 8'hA5);
      tick();
      checkOutput("midfade_rst_led_out", int'(led_out), 0);
      checkOutput("midfade_rst_settled", int'(settled), 1);

      applyStimulus(1'b1, 8'hFF);
      tick();
      releaseReset();

      expectWindow(1, 0, 1, "b_restart");
      expectWindow(64, 0, 64, "b_up");
      expectWindow(64, 3, 64, "b_up");
      expectWindow(99, 4, 99, "b_up");
      expectWindow(100, 5, 100, "b_rev");
      expectWindow(101, 5, 99, "b_rev");
      expectWindow(101, 4, 101, "b_up");
      expectWindow(128, 0, 128, "b_up");
      expectWindow(200, 5, 0, "b_rev");
      expectWindow(201, 5, 0, "b_floor");
      expectWindow(254, 0, 254, "b_up");
      expectWindow(255, 0, 255, "b_full");
      expectWindow(255, 7, 255, "b_full");
      expectWindow(265, 1, 255, "b_sat");
      expectWindow(265, 5, 0, "b_floor");

      measureWindow(1);
      measureWindow(64);
      measureWindow(99);
      applyStimulus(1'b0, 8'hDF);
      measureWindow(100);
      measureWindow(101);
      measureWindow(128);
      measureWindow(200);
      measureWindow(201);
      measureWindow(254);
      checkOutput("settled_before_full", int'(settled), 0);
      tick();
      checkOutput("settled_at_full", int'(settled), 1);
      measureWindow(255);
      measureWindow(265);
      checkOutput("settled_after_sat", int'(settled), 1);

      if (sbq.size() != 0) checkOutput("sb_leftover", sbq.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/led_fader.md
LED_FADER -- requirements
Module: led_fader

Interface
REQ-001 SHALL have parameter STEP_PERIODS, default 4, meaning the number of 256-cycle PWM periods per fade step (legal range 1..65535).
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset: synchronous and active-high.
REQ-004 SHALL have port led_in, input, 8, target on/off per LED from the SoC, asynchronous to clk.
REQ-005 SHALL have port led_out, output, 8, registered PWM drive to the LED output buffers.
REQ-006 SHALL have port settled, output, 1, registered, high when every channel has reached its target.

Function
REQ-007 SHALL pass led_in through a two-flop synchronizer; only the second-stage value (tgt) is used, giving 2 cycles of input latency.
REQ-008 SHALL keep an 8-bit free-running pwm_cnt that increments every cycle and wraps 255->0.
REQ-009 SHALL mark a period end on each cycle with pwm_cnt==255.
REQ-010 SHALL keep a step_cnt that counts period ends from 0 to STEP_PERIODS-1 and then wraps to 0.
REQ-011 SHALL raise a fade strobe on a period end while step_cnt==STEP_PERIODS-1; with STEP_PERIODS=1 the strobe fires on every period end.
REQ-012 SHALL keep one 8-bit brightness register b[i] per channel.
REQ-013 SHALL, on a fade strobe, update every channel in the same cycle: increment b[i] if tgt[i]=1, otherwise decrement it.
REQ-014 SHALL saturate each b[i] at 255 and at 0, with no wrap-around.
REQ-015 SHALL, when tgt[i] toggles mid-fade, reverse direction from the current b[i] at the next strobe, without jumping.
REQ-016 SHALL derive an 8-bit duty[i] from b[i] (see Configuration).
REQ-017 SHALL register led_out[i] as 1 when duty[i]==255, or else when pwm_cnt < duty[i]; duty 0 gives constant 0 and duty 255 gives constant 1.
REQ-018 SHALL register settled as 1 when, for all i, b[i]==255 where tgt[i]=1 and b[i]==0 where tgt[i]=0.
REQ-019 SHALL, when a fade strobe and a tgt change coincide, use the tgt value present in that cycle.

Reset
REQ-020 SHALL, while rst=1 at a clock edge, clear the synchronizer flops, pwm_cnt, step_cnt, every b[i] and led_out to 0, and set settled to 1.
REQ-021 SHALL, when reset is asserted mid-fade, abandon the fade and restart all counters from 0; no partial state survives.
REQ-022 SHALL make pwm_cnt equal 0 in the first cycle after rst deasserts, with the first fade strobe at cycle 256*STEP_PERIODS-1 after deassertion.

Configuration
REQ-023 SHALL use macro LED_FADER_GAMMA_EN: when defined, duty[i] = (b[i]*b[i])>>8 (16-bit product, upper byte), except duty=255 when b[i]==255.
REQ-024 SHALL, when LED_FADER_GAMMA_EN is undefined, use a linear mapping duty[i]=b[i] with no multiplier logic.
REQ-025 SHALL keep the macro's effect limited to the duty mapping; counters, timing, settled and reset behaviour are identical in both builds.

Verification
REQ-026 SHALL cover reset: hold rst 3 cycles with led_in=0xA5 -> led_out=0x00 and settled=1 during reset; settled falls within 4 cycles after release.
REQ-027 SHALL cover fade-up: STEP_PERIODS=1, led_in=0x01 -> b[0] reaches 255 after 255 strobes (65280 cycles plus sync latency), settled=1, and led_out[0] is constant 1.
REQ-028 SHALL cover the linear duty check: force b[3]=64 via fade, no gamma -> led_out[3] high for exactly 64 of every 256 cycles.
REQ-029 SHALL cover gamma: LED_FADER_GAMMA_EN defined, b=128 -> duty 64, giving 64 of 256 cycles high; b=16 -> duty 1, giving 1 of 256 cycles high.
REQ-030 SHALL cover reversal: led_in[5] goes 1->0 when b[5]=100 -> the next strobe gives 99, with b[5] reaching 0 after 100 strobes and no underflow.
REQ-031 SHALL cover saturation and reset mid-fade: hold led_in=0xFF for 300 strobes -> all b stay at 255; assert rst when b=50 -> all outputs return to reset values the next cycle.
